// File: rtl/l2_arbiter.sv
// ---------------------------------------------------------------------------
// l2_arbiter
//
// Shares the single Wishbone slave port of the L2 cache between two L1
// requesters: port 0 (D-cache refill/writeback) and port 1 (I-cache refill).
// One 512-bit line request is latched and presented downstream. The response
// from L2 is registered and pulsed back to the granted requester only.
//
// Ports
//   clk, rst                  CPU clock, synchronous active-high reset
//   ws0_* / ws1_*             requester side: addr, din, dm, stb, we in;
//                             ack (one-cycle pulse) and dout out
//   wm_addr/din/dm/we/stb     latched request toward L2
//   wm_ack, wm_dout           L2 acknowledge and read data
//
// Configuration macro
//   L2ARB_RR_EN  defined  : round-robin tie break through the prio pointer
//                undefined: fixed priority, requester 0 wins every tie
// ---------------------------------------------------------------------------
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int DM_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ws0_addr,
  input  logic [DATA_W-1:0] ws0_din,
  input  logic [DM_W-1:0]   ws0_dm,
  input  logic              ws0_stb,
  input  logic              ws0_we,
  output logic              ws0_ack,
  output logic [DATA_W-1:0] ws0_dout,
  input  logic [ADDR_W-1:0] ws1_addr,
  input  logic [DATA_W-1:0] ws1_din,
  input  logic [DM_W-1:0]   ws1_dm,
  input  logic              ws1_stb,
  input  logic              ws1_we,
  output logic              ws1_ack,
  output logic [DATA_W-1:0] ws1_dout,
  output logic [ADDR_W-1:0] wm_addr,
  output logic [DATA_W-1:0] wm_din,
  output logic [DM_W-1:0]   wm_dm,
  output logic              wm_we,
  output logic              wm_stb,
  input  logic              wm_ack,
  input  logic [DATA_W-1:0] wm_dout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  logic              grant_r;
  logic              stb_r;
  logic              ack0_r;
  logic              ack1_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] din_r;
  logic [DM_W-1:0]   dm_r;
  logic [DATA_W-1:0] resp_r;

  logic              req_any_s;
  logic              win_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_din_s;
  logic [DM_W-1:0]   sel_dm_s;
  logic              sel_we_s;

`ifdef L2ARB_RR_EN
  logic              prio_r;
`endif

  assign req_any_s = ws0_stb | ws1_stb;

  // Pick the winning requester for the current IDLE cycle
  always_comb begin
    win_s = 1'b0;
`ifdef L2ARB_RR_EN
    if (ws0_stb && ws1_stb) begin
      win_s = prio_r;
    end else if (ws1_stb) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`else
    // Port 1 only wins when port 0 is not asking at all
    if (ws0_stb) begin
      win_s = 1'b0;
    end else if (ws1_stb) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
`endif
  end

  // Steer the winning requester's fields toward the request latch
  always_comb begin
    sel_addr_s = ws0_addr;
    sel_din_s  = ws0_din;
    sel_dm_s   = ws0_dm;
    sel_we_s   = ws0_we;
    if (win_s) begin
      sel_addr_s = ws1_addr;
      sel_din_s  = ws1_din;
      sel_dm_s   = ws1_dm;
      sel_we_s   = ws1_we;
    end else begin
      sel_addr_s = ws0_addr;
      sel_din_s  = ws0_din;
      sel_dm_s   = ws0_dm;
      sel_we_s   = ws0_we;
    end
  end

  // Arbitration FSM: grant, wait for L2, pulse the response back
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      grant_r <= 1'b0;
      stb_r   <= 1'b0;
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      din_r   <= {DATA_W{1'b0}};
      dm_r    <= {DM_W{1'b0}};
      resp_r  <= {DATA_W{1'b0}};
`ifdef L2ARB_RR_EN
      prio_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (req_any_s) begin
            state_r <= ST_BUSY;
            stb_r   <= 1'b1;
            grant_r <= win_s;
            addr_r  <= sel_addr_s;
            din_r   <= sel_din_s;
            dm_r    <= sel_dm_s;
            we_r    <= sel_we_s;
`ifdef L2ARB_RR_EN
            prio_r  <= ~win_s;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Requester stb is not looked at here: a dropped stb still completes
          if (wm_ack) begin
            state_r <= ST_RESP;
            stb_r   <= 1'b0;
            resp_r  <= wm_dout;
            ack0_r  <= ~grant_r;
            ack1_r  <= grant_r;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          stb_r   <= 1'b0;
          ack0_r  <= 1'b0;
          ack1_r  <= 1'b0;
        end
      endcase
    end
  end

  // L2 samples stb in its idle state, which includes the ack cycle, so the
  // strobe is masked combinationally by wm_ack to avoid a phantom request.
  assign wm_stb   = stb_r & ~wm_ack;
  assign wm_addr  = addr_r;
  assign wm_din   = din_r;
  assign wm_dm    = dm_r;
  assign wm_we    = we_r;
  assign ws0_ack  = ack0_r;
  assign ws1_ack  = ack1_r;
  assign ws0_dout = resp_r;
  assign ws1_dout = resp_r;

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

  localparam int AW = 32;
  localparam int DW = 512;
  localparam int MW = 64;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ws0_addr, ws1_addr;
  logic [DW-1:0] ws0_din, ws1_din;
  logic [MW-1:0] ws0_dm, ws1_dm;
  logic          ws0_stb, ws1_stb, ws0_we, ws1_we;
  logic          ws0_ack, ws1_ack;
  logic [DW-1:0] ws0_dout, ws1_dout;
  logic [AW-1:0] wm_addr;
  logic [DW-1:0] wm_din;
  logic [MW-1:0] wm_dm;
  logic          wm_we, wm_stb, wm_ack;
  logic [DW-1:0] wm_dout;

  int n_checks = 0;
  int n_errors = 0;

  // cycle bookkeeping and L2 / requester models
  int            cyc = 0;
  int            stb_rise_cyc = 0;
  int            wmack_cyc = 0;
  int            ack_cyc = 0;
  logic          stb_last = 1'b0;
  int            l2_reqs = 0;
  int            l2_delay = 5;
  bit            manual = 1'b0;
  bit            l2_busy = 1'b0;
  int            l2_cnt = 0;
  logic [DW-1:0] l2_data = '0;
  int            cnt0 = 0;
  int            cnt1 = 0;
  logic          a0 = 1'b0;
  logic          a1 = 1'b0;

  l2_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DM_W(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ws0_addr (ws0_addr),
    .ws0_din  (ws0_din),
    .ws0_dm   (ws0_dm),
    .ws0_stb  (ws0_stb),
    .ws0_we   (ws0_we),
    .ws0_ack  (ws0_ack),
    .ws0_dout (ws0_dout),
    .ws1_addr (ws1_addr),
    .ws1_din  (ws1_din),
    .ws1_dm   (ws1_dm),
    .ws1_stb  (ws1_stb),
    .ws1_we   (ws1_we),
    .ws1_ack  (ws1_ack),
    .ws1_dout (ws1_dout),
    .wm_addr  (wm_addr),
    .wm_din   (wm_din),
    .wm_dm    (wm_dm),
    .wm_we    (wm_we),
    .wm_stb   (wm_stb),
    .wm_ack   (wm_ack),
    .wm_dout  (wm_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for an ack pulse; returns the port that got it
  task automatic wait_ack(output int p);
    p = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (ws0_ack && ws1_ack) check("both_acks", 512'd1, 512'd0);
      if (ws0_ack) begin p = 0; break; end
      if (ws1_ack) begin p = 1; break; end
    end
    if (p < 0) check("ack_timeout", 512'd1, 512'd0);
  endtask

  // L2 slave model and requester stb-drop model
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      a0 = ws0_ack;
      a1 = ws1_ack;
      if (wm_ack) begin
        check("stb_in_ack", 512'(wm_stb), 512'd0);
        wmack_cyc = cyc;
      end
      if (wm_stb && !stb_last) stb_rise_cyc = cyc;
      stb_last = wm_stb;
      if (a0 || a1) ack_cyc = cyc;
      if (rst) l2_busy = 1'b0;
      else if (!manual && !l2_busy && wm_stb) begin
        l2_busy = 1'b1;
        l2_cnt  = 0;
        l2_reqs++;
      end
      @(posedge clk); #1;
      if (a0 && cnt0 > 0) begin cnt0--; if (cnt0 == 0) ws0_stb = 1'b0; end
      if (a1 && cnt1 > 0) begin cnt1--; if (cnt1 == 0) ws1_stb = 1'b0; end
      if (!manual) begin
        if (rst || wm_ack) begin
          wm_ack  = 1'b0;
          l2_busy = 1'b0;
        end else if (l2_busy) begin
          l2_cnt++;
          if (l2_cnt >= l2_delay) begin
            wm_ack  = 1'b1;
            wm_dout = l2_data;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, c0, r0, prev_ack;
    int exp_g[4];
    logic [DW-1:0] d1, d2, d3, d4, dwr;
    d1  = {16{32'h1234_5678}};
    d2  = {16{32'hA5A5_0F0F}};
    d3  = {16{32'h0BAD_F00D}};
    d4  = {16{32'hC0DE_1111}};
    dwr = {16{32'h8765_4321}};
`ifdef L2ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 1, 1};
`endif

    rst = 1'b1;
    ws0_addr = '0; ws1_addr = '0; ws0_din = '0; ws1_din = '0;
    ws0_dm = '0; ws1_dm = '0; ws0_stb = 1'b0; ws1_stb = 1'b0;
    ws0_we = 1'b0; ws1_we = 1'b0; wm_ack = 1'b0; wm_dout = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_wm_stb",  512'(wm_stb),  512'd0);
    check("rst_ws0_ack", 512'(ws0_ack), 512'd0);
    check("rst_ws1_ack", 512'(ws1_ack), 512'd0);
    check("rst_wm_addr", 512'(wm_addr), 512'd0);
    check("rst_wm_din",  wm_din,        512'd0);
    check("rst_wm_dm",   512'(wm_dm),   512'd0);
    check("rst_wm_we",   512'(wm_we),   512'd0);
    check("rst_dout",    ws0_dout,      512'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // single read on port 1, L2 acks 5 cycles after stb
    l2_delay = 5; l2_data = d1;
    ws1_addr = 32'h003F_FFC0; ws1_we = 1'b0; cnt1 = 1; ws1_stb = 1'b1;
    c0 = cyc; r0 = l2_reqs;
    wait_ack(p);
    check("t1_port",     512'(p),            512'd1);
    check("t1_addr",     512'(wm_addr),      512'(32'h003F_FFC0));
    check("t1_we",       512'(wm_we),        512'd0);
    check("t1_dout",     ws1_dout,           d1);
    check("t1_ack0",     512'(ws0_ack),      512'd0);
    check("t1_stb_lat",  512'(stb_rise_cyc), 512'(c0 + 1));
    check("t1_l2_lat",   512'(wmack_cyc),    512'(stb_rise_cyc + 5));
    check("t1_ack_lat",  512'(ack_cyc),      512'(wmack_cyc + 1));
    @(negedge clk); #1;
    check("t1_ack_1cyc", 512'(ws1_ack),      512'd0);
    check("t1_l2_reqs",  512'(l2_reqs),      512'(r0 + 1));

    // both ports requesting two lines each
    ws0_addr = 32'h0000_0040; ws1_addr = 32'h0040_0040;
    ws0_we = 1'b0; ws1_we = 1'b0;
    l2_delay = 2; l2_data = d2;
    cnt0 = 2; cnt1 = 2; ws0_stb = 1'b1; ws1_stb = 1'b1;
    r0 = l2_reqs; prev_ack = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(p);
      check("t2_grant", 512'(p), 512'(exp_g[k]));
      check("t2_addr",  512'(wm_addr), (p == 1) ? 512'(32'h0040_0040) : 512'(32'h0000_0040));
      check("t2_dout",  (p == 1) ? ws1_dout : ws0_dout, d2);
      if (k > 0) check("t2_regrant", 512'(stb_rise_cyc), 512'(prev_ack + 2));
      prev_ack = ack_cyc;
    end
    repeat (3) @(negedge clk);
    #1;
    check("t2_l2_reqs", 512'(l2_reqs), 512'(r0 + 4));

    // write pass-through on port 0
    ws0_we = 1'b1; ws0_dm = 64'hFFFF_FFFF_FFFF_FFFF; ws0_din = dwr;
    ws0_addr = 32'h0000_1000; l2_delay = 3; l2_data = d3;
    cnt0 = 1; ws0_stb = 1'b1; r0 = l2_reqs;
    wait_ack(p);
    check("t3_port", 512'(p),       512'd0);
    check("t3_din",  wm_din,        dwr);
    check("t3_dm",   512'(wm_dm),   512'(64'hFFFF_FFFF_FFFF_FFFF));
    check("t3_we",   512'(wm_we),   512'd1);
    check("t3_dout", ws0_dout,      d3);
    check("t3_ack1", 512'(ws1_ack), 512'd0);
    @(negedge clk); #1;
    check("t3_ack_1cyc", 512'(ws0_ack), 512'd0);
    check("t3_l2_reqs",  512'(l2_reqs), 512'(r0 + 1));
    ws0_we = 1'b0; ws0_dm = '0;

    // L2 acks in the very first BUSY cycle
    manual = 1'b1;
    ws1_addr = 32'h0000_2000; cnt1 = 1; ws1_stb = 1'b1;
    @(posedge clk); #1;
    wm_ack = 1'b1; wm_dout = d4;
    @(negedge clk); #1;
    check("t4_stb_masked", 512'(wm_stb),  512'd0);
    check("t4_addr",       512'(wm_addr), 512'(32'h0000_2000));
    @(posedge clk); #1;
    wm_ack = 1'b0;
    @(negedge clk); #1;
    check("t4_ack1", 512'(ws1_ack), 512'd1);
    check("t4_dout", ws1_dout,      d4);
    check("t4_ack0", 512'(ws0_ack), 512'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("t4_no_rereq", 512'(wm_stb), 512'd0);
    end
    manual = 1'b0;

    // reset two cycles after grant aborts the transaction
    l2_delay = 8; l2_data = d1;
    ws0_addr = 32'h0000_3000; cnt0 = 1; ws0_stb = 1'b1;
    @(negedge clk); #1;
    check("t5_busy_stb", 512'(wm_stb), 512'd1);
    @(negedge clk); #1;
    rst = 1'b1; ws0_stb = 1'b0; cnt0 = 0;
    @(negedge clk); #1;
    check("t5_rst_stb",  512'(wm_stb),  512'd0);
    check("t5_rst_ack0", 512'(ws0_ack), 512'd0);
    check("t5_rst_ack1", 512'(ws1_ack), 512'd0);
    check("t5_rst_addr", 512'(wm_addr), 512'd0);
    check("t5_rst_dout", ws0_dout,      512'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("t5_quiet", 512'({ws0_ack, ws1_ack, wm_stb}), 512'd0);
    end
    // prio restarts at port 0, then port 1 is served normally
    l2_delay = 2; l2_data = d2;
    ws0_addr = 32'h0000_5000; ws1_addr = 32'h0000_4000;
    cnt0 = 1; cnt1 = 1; ws0_stb = 1'b1; ws1_stb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(p);
      check("t5_grant", 512'(p), 512'(k));
      check("t5_addr",  512'(wm_addr), (k == 1) ? 512'(32'h0000_4000) : 512'(32'h0000_5000));
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
